// File: rtl/tone_synth.sv
// Reference-tone synthesiser: a phase accumulator drives square/saw/triangle
// samples into the audio codec output FIFO, one sample per tick.
module tone_synth #(
  parameter int unsigned CLK_DIV      = 1042,
  parameter int unsigned PHASE_SCALE  = 89478,
  parameter int unsigned VOLUME_SHIFT = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] frequency,
  input  logic [1:0]  wave_sel,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [7:0]  dropped,
  output logic        busy
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t               state;
  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic [31:0]          phase;
  logic [31:0]          inc;
  logic [31:0]          inc_next;
  logic [1:0]           wave;
  logic [22:0]          tri_t;
  logic [23:0]          s;
  logic signed [31:0]   sample;

  assign tick     = enable && (tick_cnt == LAST);
  assign inc_next = 32'(frequency) * PHASE_SCALE;
  assign busy     = (state != IDLE);

  // Strobe is qualified by the live handshake so it lands in the very cycle
  // the FIFO reports space; enable gates it so a dropped run never writes.
  assign write_audio_out = enable && (state == WRITE) && audio_out_allowed;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_comb begin
    s     = '0;
    tri_t = phase[31] ? ~phase[30:8] : phase[30:8];
    case (wave)
      2'd0:    s = phase[31] ? 24'h800001 : 24'h7FFFFF;
      2'd1:    s = phase[31:8] ^ 24'h800000;
      2'd2:    s = {tri_t, 1'b0} ^ 24'h800000;
      default: s = '0;
    endcase
    sample = $signed({{8{s[23]}}, s}) >>> VOLUME_SHIFT;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      phase                   <= '0;
      inc                     <= '0;
      wave                    <= '0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      dropped                 <= '0;
    end else if (!enable) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      if (tick && (state != IDLE) && (dropped != 8'hFF)) begin
        dropped <= dropped + 8'd1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            inc   <= inc_next;
            wave  <= wave_sel;
            state <= CALC;
          end
        end
        CALC: begin
          left_channel_audio_out  <= sample;
          right_channel_audio_out <= sample;
          phase                   <= phase + inc;
          state                   <= WRITE;
        end
        WRITE: begin
          if (audio_out_allowed) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: expected samples are queued by the stimulus
// and popped by per-instance write monitors.
module tb_tone_synth;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        en2 = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic [15:0] frequency = '0;
  logic [15:0] freq2 = '0;
  logic [1:0]  wave_sel = '0;
  logic [1:0]  wave2 = '0;

  logic        wr1, wr2, busy1, busy2;
  logic [31:0] l1, r1, l2, r2;
  logic [7:0]  drop1, drop2;

  always #5 clk = ~clk;

  tone_synth #(.CLK_DIV(4), .PHASE_SCALE(89478), .VOLUME_SHIFT(0)) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .frequency(frequency),
    .wave_sel(wave_sel), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(wr1), .left_channel_audio_out(l1),
    .right_channel_audio_out(r1), .dropped(drop1), .busy(busy1)
  );

  // Scale of 2^15 lets frequency 2^15 produce an increment of exactly 2^30.
  tone_synth #(.CLK_DIV(4), .PHASE_SCALE(32768), .VOLUME_SHIFT(0)) dut2 (
    .CLOCK_50(clk), .reset(reset), .enable(en2), .frequency(freq2),
    .wave_sel(wave2), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(wr2), .left_channel_audio_out(l2),
    .right_channel_audio_out(r2), .dropped(drop2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr1_cnt = 0;
  int wr2_cnt = 0;
  int wr_times[$];
  logic [31:0] exp1[$];
  logic [31:0] exp2[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input bit second, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((second ? wr2_cnt : wr1_cnt) >= target) break;
      step(1);
    end
    check(second ? "dut2_write_count" : "dut_write_count",
          32'(second ? wr2_cnt : wr1_cnt), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    en2 = 1'b0;
    audio_out_allowed = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && wr1) begin
      wr1_cnt++;
      wr_times.push_back(cyc);
      if (exp1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut_unexpected_write actual=%h required=no_write", l1);
      end else begin
        automatic logic [31:0] e = exp1.pop_front();
        check("dut_left", l1, e);
        check("dut_right", r1, e);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && wr2) begin
      wr2_cnt++;
      if (exp2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut2_unexpected_write actual=%h required=no_write", l2);
      end else begin
        automatic logic [31:0] e = exp2.pop_front();
        check("dut2_left", l2, e);
        check("dut2_right", r2, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base;

    // reset state
    step(2);
    check("rst_write", 32'(wr1), 32'd0);
    check("rst_left", l1, 32'd0);
    check("rst_right", r1, 32'd0);
    check("rst_dropped", 32'(drop1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_phase", dut.phase, 32'd0);

    // square tone, then silence continuing from kept outputs
    do_reset();
    frequency = 16'd12000;
    wave_sel = 2'd0;
    audio_out_allowed = 1'b1;
    repeat (3) exp1.push_back(32'h007FFFFF);
    repeat (2) exp1.push_back(32'hFF800001);
    base = wr1_cnt;
    wr_times.delete();
    enable = 1'b1;
    wait_wr(1'b0, base + 5, 60);
    check("sq_inc", dut.inc, 32'h3FFFE940);
    check("sq_phase5", dut.phase, 32'h3FFF8E40);
    if (wr_times.size() == 5)
      for (int i = 1; i < 5; i++) check("sq_cadence", 32'(wr_times[i] - wr_times[i-1]), 32'd4);
    enable = 1'b0;
    step(2);
    check("dis_left_kept", l1, 32'hFF800001);
    check("dis_busy", 32'(busy1), 32'd0);
    check("dis_phase", dut.phase, 32'd0);
    wave_sel = 2'd3;
    repeat (2) exp1.push_back(32'h00000000);
    base = wr1_cnt;
    enable = 1'b1;
    wait_wr(1'b0, base + 2, 40);
    enable = 1'b0;

    // triangle on both instances, then sawtooth on the 2^30-increment instance
    do_reset();
    frequency = 16'd12000;
    wave_sel = 2'd2;
    freq2 = 16'd32768;
    wave2 = 2'd2;
    audio_out_allowed = 1'b1;
    exp1.push_back(32'hFF800000);
    exp1.push_back(32'hFFFFFFD2);
    exp1.push_back(32'h007FFFA4);
    exp2.push_back(32'hFF800000);
    exp2.push_back(32'h00000000);
    exp2.push_back(32'h007FFFFE);
    base = wr1_cnt;
    k = wr2_cnt;
    enable = 1'b1;
    en2 = 1'b1;
    wait_wr(1'b0, base + 3, 40);
    wait_wr(1'b1, k + 3, 40);
    check("tri_inc2", dut2.inc, 32'h40000000);
    enable = 1'b0;
    en2 = 1'b0;
    step(2);
    wave2 = 2'd1;
    exp2.push_back(32'hFF800000);
    exp2.push_back(32'hFFC00000);
    exp2.push_back(32'h00000000);
    k = wr2_cnt;
    en2 = 1'b1;
    wait_wr(1'b1, k + 3, 40);
    en2 = 1'b0;

    // backpressure; allowed rises in the cycle of the third tick
    do_reset();
    frequency = 16'd12000;
    wave_sel = 2'd0;
    repeat (3) exp1.push_back(32'h007FFFFF);
    base = wr1_cnt;
    wr_times.delete();
    enable = 1'b1;
    step(11);
    check("bp_dropped_mid", 32'(drop1), 32'd1);
    audio_out_allowed = 1'b1;
    wait_wr(1'b0, base + 3, 40);
    check("bp_dropped", 32'(drop1), 32'd2);
    if (wr_times.size() == 3) check("bp_cadence", 32'(wr_times[2] - wr_times[1]), 32'd4);
    enable = 1'b0;

    // dropped saturation
    do_reset();
    enable = 1'b1;
    step(400);
    check("sat_dropped_99", 32'(drop1), 32'd99);
    step(800);
    check("sat_dropped_255", 32'(drop1), 32'd255);
    check("sat_busy", 32'(busy1), 32'd1);
    enable = 1'b0;
    step(2);
    check("sat_dropped_hold", 32'(drop1), 32'd255);

    // enable drop while waiting in WRITE
    do_reset();
    frequency = 16'd12000;
    wave_sel = 2'd0;
    enable = 1'b1;
    step(6);
    check("en_busy_write", 32'(busy1), 32'd1);
    enable = 1'b0;
    audio_out_allowed = 1'b1;
    step(1);
    check("en_busy_idle", 32'(busy1), 32'd0);
    check("en_phase_clr", dut.phase, 32'd0);
    check("en_left_kept", l1, 32'h007FFFFF);
    step(5);
    exp1.push_back(32'h007FFFFF);
    base = wr1_cnt;
    enable = 1'b1;
    wait_wr(1'b0, base + 1, 20);
    enable = 1'b0;

    // asynchronous reset mid-WRITE
    do_reset();
    frequency = 16'd12000;
    wave_sel = 2'd0;
    enable = 1'b1;
    step(12);
    check("ar_dropped_pre", 32'(drop1), 32'd2);
    check("ar_left_pre", l1, 32'h007FFFFF);
    #2;
    reset = 1'b1;
    audio_out_allowed = 1'b1;
    #1;
    check("ar_write", 32'(wr1), 32'd0);
    check("ar_left", l1, 32'd0);
    check("ar_right", r1, 32'd0);
    check("ar_dropped", 32'(drop1), 32'd0);
    check("ar_busy", 32'(busy1), 32'd0);
    exp1.push_back(32'h007FFFFF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!wr1 && k < 20);
    check("ar_first_write_cycles", 32'(k), 32'd5);
    step(1);
    enable = 1'b0;

    step(10);
    check("dut_queue_empty", 32'(exp1.size()), 32'd0);
    check("dut2_queue_empty", 32'(exp2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Audio-output counterpart to the tuner's capture path.
- Synthesises a tone at a requested frequency in Hz.
- Produces one 24-bit sample (sign-extended to 32 bits) per sample tick and pushes it to the audio codec output FIFO with the codec's allowed/write handshake.
- Sits beside the tuner, fed by the tuner's frequency result or by switches, for reference-tone playback.

Parameters:
- CLK_DIV, 1042: CLOCK_50 cycles per sample tick (about 48 kHz).
- PHASE_SCALE, 89478: phase increment per Hz, equal to 2^32/48000 truncated.
- VOLUME_SHIFT, 0: arithmetic right shift applied to every sample (0–23).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run synthesis; low = idle, phase cleared.
- frequency  in  16  tone frequency in Hz, latched at each sample tick.
- wave_sel  in  2  waveform: 0 square, 1 sawtooth, 2 triangle, 3 silence.
- audio_out_allowed  in  1  codec output FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to codec.
- left_channel_audio_out  out  32  signed sample.
- right_channel_audio_out  out  32  same value as left.
- dropped  out  8  saturating count of ticks lost while a write was pending.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - Tick counter, phase, both channel outputs, write_audio_out, dropped and busy are all 0.
- Tick counter:
  - Counts 0..CLK_DIV-1 while enable=1.
  - tick=1 for the single cycle in which the count is CLK_DIV-1, then the count wraps to 0.
  - enable=0 holds the count at 0.
- State machine (IDLE, CALC, WRITE):
  - IDLE: on tick, latch inc = (frequency*PHASE_SCALE)[31:0] (33-bit product, truncated), then go to CALC.
  - CALC (one cycle):
    - Compute the sample from the current phase.
    - Register the sample into both channel outputs.
    - Update phase <= phase + inc, mod 2^32.
    - Go to WRITE.
  - WRITE:
    - Hold data stable.
    - In the first cycle where audio_out_allowed=1, assert write_audio_out for exactly that one cycle, then return to IDLE.
    - If audio_out_allowed is already 1 on entry, the write occurs in the first WRITE cycle. Tick-to-strobe latency is therefore 2 cycles.
- Sample generation (24-bit s; output = sign-extend(s) >>> VOLUME_SHIFT):
  - Square: phase[31]=0 gives +0x7FFFFF; otherwise -0x7FFFFF.
  - Sawtooth: s = phase[31:8] ^ 0x800000.
  - Triangle:
    - t = phase[31] ? ~phase[30:8] : phase[30:8].
    - s = {t,1'b0} ^ 0x800000.
  - Silence: s = 0, still written at the sample rate.
- Boundary conditions:
  - Tick while in CALC or WRITE: the tick is discarded, phase is not advanced, and dropped increments, saturating at 255. Only reset clears dropped.
  - Tick and audio_out_allowed rising in the same WRITE cycle: the write completes and the tick counts as dropped.
  - frequency=0: inc=0, giving a constant sample at phase 0.
  - Phase wraps silently at 2^32.
  - enable falls in any state:
    - Next cycle, state is IDLE and phase is 0.
    - A pending write is abandoned and write_audio_out stays 0.
    - Channel outputs keep their last value.
    - dropped is not changed.
  - Frequency and wave_sel changes take effect only at the next accepted tick.

Test Plan (CLK_DIV=4, VOLUME_SHIFT=0 unless noted):
1. Square tone:
   - Stimulus: frequency=12000 (inc=0x3FFFE940), wave_sel=0, audio_out_allowed=1, enable=1.
   - Required: five writes, one every 4 cycles, with values 0x007FFFFF ×3 then 0xFF800001 ×2.
   - Required: phase after the 5th write = 0x3FFF8E40.
   - Required: left equals right on every write.
2. Triangle:
   - Stimulus: frequency=12000, wave_sel=2.
   - Required: first sample 0xFF800000.
   - Required: the phase value 0x7FFFD280 gives t=0x7FFFD2, and the sample equals sign-extend(0x7FFFA4).
   - Separately, force inc=0x40000000 (frequency chosen so the product truncates to 0x40000000). Required sample sequence: 0xFF800000, 0x00000000, 0x007FFFFE.
3. Backpressure:
   - Stimulus: audio_out_allowed=0 for 3 tick periods, then 1.
   - Required: dropped=2 (first tick accepted, next two dropped).
   - Required: exactly one write, carrying the first sample, then normal cadence.
4. Saturation:
   - Stimulus: audio_out_allowed=0 for 300 ticks.
   - Required: dropped stops at 255 with no wrap, and write_audio_out is never asserted.
5. Enable drop:
   - Stimulus: deassert enable while in WRITE, then reassert.
   - Required: no strobe while enable=0.
   - Required: after re-enable, first square sample is 0x007FFFFF (phase restarted at 0).
6. Async reset:
   - Stimulus: assert reset mid-WRITE, between clock edges.
   - Required: all outputs 0 immediately, before the next edge.
   - Required: after reset release with enable=1, the first write occurs 5 cycles later.
